// File: rtl/mem_access_unit_pkg.sv
// Shared types for the MEM-stage data-memory controller.
package mem_access_unit_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {IDLE, REQ, DONE} mem_state_t;
  typedef enum logic [1:0] {OP_LW, OP_SW, OP_LL, OP_SC} mem_op_t;

  typedef logic [ADDR_W_DEF-1:0] addr_t;
  typedef logic [DATA_W_DEF-1:0] word_t;

  // LL/SC flags take priority over the plain read/write strobes.
  function automatic mem_op_t decode_op(input logic ll, input logic sc, input logic wen);
    if (ll)       return OP_LL;
    else if (sc)  return OP_SC;
    else if (wen) return OP_SW;
    else          return OP_LW;
  endfunction

endpackage

// File: rtl/mem_access_unit_ll_sc_link.sv
// LL/SC link register: set by LL completion, cleared by SC completion,
// by a local store to the linked word, or by a matching coherence snoop.
module ll_sc_link
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              i_set,
  input  logic [ADDR_W-1:0] i_set_addr,
  input  logic              i_clr_sc,
  input  logic              i_clr_st,
  input  logic [ADDR_W-1:0] i_st_addr,
  input  logic              i_snoop_inv,
  input  logic [ADDR_W-1:0] i_snoop_addr,
  input  logic [ADDR_W-1:0] i_chk_addr,
  output logic              o_sc_ok
);

  logic              r_link_valid;
  logic [ADDR_W-1:0] r_link_addr;
  logic              w_snoop_hit;
  logic              w_snoop_set;
  logic              w_st_hit;
  logic              w_unused;

  // Links are word granular; byte offsets never take part in a compare.
  assign w_unused    = ^{i_snoop_addr[1:0], i_st_addr[1:0], i_chk_addr[1:0]};
  assign w_snoop_hit = i_snoop_inv && (i_snoop_addr[ADDR_W-1:2] == r_link_addr[ADDR_W-1:2]);
  assign w_snoop_set = i_snoop_inv && (i_snoop_addr[ADDR_W-1:2] == i_set_addr[ADDR_W-1:2]);
  assign w_st_hit    = i_clr_st && (i_st_addr[ADDR_W-1:2] == r_link_addr[ADDR_W-1:2]);

  // A snoop landing in the same cycle as the SC check already kills the link.
  assign o_sc_ok = r_link_valid && !w_snoop_hit &&
                   (i_chk_addr[ADDR_W-1:2] == r_link_addr[ADDR_W-1:2]);

  // Link state; a snoop racing an LL completion to the same word wins.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_link_valid <= 1'b0;
      r_link_addr  <= '0;
    end else if (i_set) begin
      r_link_valid <= !w_snoop_set;
      r_link_addr  <= i_set_addr;
    end else if (i_clr_sc || w_st_hit || w_snoop_hit) begin
      r_link_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory controller: one cache transaction per memory op,
// pipeline stall while outstanding, LL/SC link tracking.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              valid_EX_MEM,
  input  logic              flush_MEM,
  input  logic              memREN_EX_MEM,
  input  logic              memWEN_EX_MEM,
  input  logic              LL_EX_MEM,
  input  logic              SC_EX_MEM,
  input  logic [ADDR_W-1:0] addr_EX_MEM,
  input  logic [DATA_W-1:0] store_data_EX_MEM,
  input  logic              dhit,
  input  logic [DATA_W-1:0] dmemload_cache,
  input  logic              snoop_inv,
  input  logic [ADDR_W-1:0] snoop_addr,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [ADDR_W-1:0] dmemaddr,
  output logic [DATA_W-1:0] dmemstore,
  output logic [DATA_W-1:0] dmemload_MEM,
  output logic [DATA_W-1:0] sc_result_MEM,
  output logic              mem_busy
);

  mem_state_t        r_state, w_next_state;
  mem_op_t           r_op;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_load;
  logic              r_sc_result;

  logic    w_op_present;
  mem_op_t w_op_in;
  logic    w_capture;
  logic    w_sc_fail;
  logic    w_sc_ok;
  logic    w_complete;
  logic    w_rd_op;

  assign w_op_present = valid_EX_MEM && !flush_MEM && (memREN_EX_MEM || memWEN_EX_MEM);
  assign w_op_in      = decode_op(LL_EX_MEM, SC_EX_MEM, memWEN_EX_MEM);
  assign w_complete   = (r_state == REQ) && dhit;
  assign w_rd_op      = (r_op == OP_LW) || (r_op == OP_LL);

  // Next state: a doomed SC skips the cache entirely and goes straight to DONE.
  always_comb begin
    w_next_state = r_state;
    w_capture    = 1'b0;
    w_sc_fail    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_op_present) begin
          w_capture = 1'b1;
          if (w_op_in == OP_SC && !w_sc_ok) begin
            w_sc_fail    = 1'b1;
            w_next_state = DONE;
          end else begin
            w_next_state = REQ;
          end
        end
      end
      REQ:     if (dhit) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // State register; reset abandons any outstanding request.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // Capture the op in IDLE so the request never depends on EX/MEM afterwards.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_op    <= OP_LW;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_capture) begin
      r_op    <= w_op_in;
      r_addr  <= addr_EX_MEM;
      r_wdata <= store_data_EX_MEM;
    end
  end

  // Results held for MEM/WB until the next completing load or SC.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_load      <= '0;
      r_sc_result <= 1'b0;
    end else begin
      if (w_complete && w_rd_op)        r_load <= dmemload_cache;
      if (w_complete && r_op == OP_SC)  r_sc_result <= 1'b1;
      else if (w_sc_fail)               r_sc_result <= 1'b0;
    end
  end

  ll_sc_link #(.ADDR_W(ADDR_W)) u_link (
    .CLK          (CLK),
    .nRST         (nRST),
    .i_set        (w_complete && r_op == OP_LL),
    .i_set_addr   (r_addr),
    .i_clr_sc     (w_complete && r_op == OP_SC),
    .i_clr_st     (w_complete && r_op == OP_SW),
    .i_st_addr    (r_addr),
    .i_snoop_inv  (snoop_inv),
    .i_snoop_addr (snoop_addr),
    .i_chk_addr   (addr_EX_MEM),
    .o_sc_ok      (w_sc_ok)
  );

  // Request decoded from registered state only, so dhit never reaches it.
  assign dmemREN       = (r_state == REQ) && w_rd_op;
  assign dmemWEN       = (r_state == REQ) && !w_rd_op;
  assign dmemaddr      = (r_state == REQ) ? r_addr : '0;
  assign dmemstore     = dmemWEN ? r_wdata : '0;
  assign dmemload_MEM  = r_load;
  assign sc_result_MEM = {{(DATA_W-1){1'b0}}, r_sc_result};
  assign mem_busy      = ((r_state == IDLE) && w_op_present) || (r_state == REQ);

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: expected step results are queued
// when an op is driven and compared when the DUT reaches DONE.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        valid_EX_MEM = 0, flush_MEM = 0, memREN_EX_MEM = 0, memWEN_EX_MEM = 0;
  logic        LL_EX_MEM = 0, SC_EX_MEM = 0, dhit = 0, snoop_inv = 0;
  logic [31:0] addr_EX_MEM = 0, store_data_EX_MEM = 0, dmemload_cache = 0, snoop_addr = 0;
  logic        dmemREN, dmemWEN, mem_busy;
  logic [31:0] dmemaddr, dmemstore, dmemload_MEM, sc_result_MEM;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    mem_op_t     op;
    logic [31:0] addr, data;
    int          dly;
    bit          snp, flr;
    int          busy, ren, wen;
    logic [31:0] load, sc;
  } step_t;

  typedef struct {
    int          busy, ren, wen, bad;
    logic [31:0] load, sc;
  } obs_t;

  step_t sb[$];

  mem_access_unit dut (
    .CLK(CLK), .nRST(nRST), .valid_EX_MEM(valid_EX_MEM), .flush_MEM(flush_MEM),
    .memREN_EX_MEM(memREN_EX_MEM), .memWEN_EX_MEM(memWEN_EX_MEM),
    .LL_EX_MEM(LL_EX_MEM), .SC_EX_MEM(SC_EX_MEM), .addr_EX_MEM(addr_EX_MEM),
    .store_data_EX_MEM(store_data_EX_MEM), .dhit(dhit), .dmemload_cache(dmemload_cache),
    .snoop_inv(snoop_inv), .snoop_addr(snoop_addr), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore), .dmemload_MEM(dmemload_MEM),
    .sc_result_MEM(sc_result_MEM), .mem_busy(mem_busy)
  );

  always #5 CLK = ~CLK;

  function automatic step_t mk(mem_op_t op, logic [31:0] a, logic [31:0] d, int dly, bit snp, bit flr,
                               int busy, int ren, int wen, logic [31:0] load, logic [31:0] sc);
    step_t s;
    s.op = op; s.addr = a; s.data = d; s.dly = dly; s.snp = snp; s.flr = flr;
    s.busy = busy; s.ren = ren; s.wen = wen; s.load = load; s.sc = sc;
    return s;
  endfunction

  task automatic drive_idle();
    valid_EX_MEM = 0; flush_MEM = 0; memREN_EX_MEM = 0; memWEN_EX_MEM = 0;
    LL_EX_MEM = 0; SC_EX_MEM = 0;
  endtask

  // Drives one op like the EX/MEM register would and acts as the cache.
  // Returns what was observed; bad counts integrity problems and timeouts.
  task automatic run_op(input step_t s, output obs_t o);
    bit seen = 0;
    int req_n = 0;
    bit done = 0;
    o.busy = 0; o.ren = 0; o.wen = 0; o.bad = 0; o.load = 'x; o.sc = 'x;
    @(negedge CLK);
    valid_EX_MEM  = 1;
    memREN_EX_MEM = (s.op == OP_LW || s.op == OP_LL);
    memWEN_EX_MEM = (s.op == OP_SW || s.op == OP_SC);
    LL_EX_MEM = (s.op == OP_LL); SC_EX_MEM = (s.op == OP_SC);
    addr_EX_MEM = s.addr; store_data_EX_MEM = s.data; flush_MEM = 0;
    for (int c = 0; c < 60; c++) begin
      #1;
      if (dmemREN && dmemWEN) o.bad++;
      if (dmemREN) o.ren++;
      if (dmemWEN) o.wen++;
      if (dmemREN || dmemWEN) begin
        req_n++;
        if (dmemaddr !== s.addr || (dmemWEN && dmemstore !== s.data)) o.bad++;
        if (s.flr) flush_MEM = 1;
        if (req_n == s.dly + 1) begin
          dhit = 1; dmemload_cache = s.data;
          if (s.snp) begin snoop_inv = 1; snoop_addr = s.addr; end
        end
      end
      if (mem_busy) begin
        o.busy++; seen = 1;
      end else if (seen) begin
        o.load = dmemload_MEM; o.sc = sc_result_MEM; done = 1;
        break;
      end
      @(negedge CLK);
      dhit = 0; snoop_inv = 0; dmemload_cache = 32'hBAADF00D;
    end
    if (!done) begin
      o.bad++;
      $display("FAIL run_op timeout: op %s addr %h never reached DONE", s.op.name(), s.addr);
    end
    @(negedge CLK);
    drive_idle();
  endtask

  task automatic snoop_pulse(input logic [31:0] a);
    @(negedge CLK);
    snoop_inv = 1; snoop_addr = a;
    #1;
    n_assert++;
    if (mem_busy !== 1'b0) begin n_fail++; $display("FAIL snoop_busy: got %b want 0", mem_busy); end
    @(negedge CLK);
    snoop_inv = 0;
  endtask

  task automatic test_reset();
    nRST = 0;
    #1;
    n_assert++; if (dmemREN !== 0)   begin n_fail++; $display("FAIL reset_ren: got %b want 0", dmemREN); end
    n_assert++; if (dmemWEN !== 0)   begin n_fail++; $display("FAIL reset_wen: got %b want 0", dmemWEN); end
    n_assert++; if (dmemaddr !== 0)  begin n_fail++; $display("FAIL reset_addr: got %h want 0", dmemaddr); end
    n_assert++; if (dmemstore !== 0) begin n_fail++; $display("FAIL reset_store: got %h want 0", dmemstore); end
    n_assert++; if (dmemload_MEM !== 0)  begin n_fail++; $display("FAIL reset_load: got %h want 0", dmemload_MEM); end
    n_assert++; if (sc_result_MEM !== 0) begin n_fail++; $display("FAIL reset_sc: got %h want 0", sc_result_MEM); end
    n_assert++; if (mem_busy !== 0)  begin n_fail++; $display("FAIL reset_busy: got %b want 0", mem_busy); end
    repeat (2) @(negedge CLK);
    nRST = 1;
  endtask

  // Runs a table of steps through the scoreboard and checks each completion.
  task automatic test_steps(input string nm, input step_t st[$]);
    obs_t  o;
    step_t e;
    foreach (st[i]) begin
      sb.push_back(st[i]);
      run_op(st[i], o);
      e = sb.pop_front();
      n_assert++; if (o.busy !== e.busy) begin n_fail++; $display("FAIL %s[%0d] busy_cycles: got %0d want %0d", nm, i, o.busy, e.busy); end
      n_assert++; if (o.ren !== e.ren)   begin n_fail++; $display("FAIL %s[%0d] ren_cycles: got %0d want %0d", nm, i, o.ren, e.ren); end
      n_assert++; if (o.wen !== e.wen)   begin n_fail++; $display("FAIL %s[%0d] wen_cycles: got %0d want %0d", nm, i, o.wen, e.wen); end
      n_assert++; if (o.load !== e.load) begin n_fail++; $display("FAIL %s[%0d] dmemload: got %h want %h", nm, i, o.load, e.load); end
      n_assert++; if (o.sc !== e.sc)     begin n_fail++; $display("FAIL %s[%0d] sc_result: got %h want %h", nm, i, o.sc, e.sc); end
      n_assert++; if (o.bad !== 0)       begin n_fail++; $display("FAIL %s[%0d] request_integrity: got %0d errors want 0", nm, i, o.bad); end
    end
  endtask

  task automatic test_lw();
    step_t st[$];
    st.push_back(mk(OP_LW, 32'h100, 32'hDEADBEEF, 2, 0, 0, 4, 3, 0, 32'hDEADBEEF, 0));
    st.push_back(mk(OP_SW, 32'h104, 32'h12345678, 0, 0, 0, 2, 0, 1, 32'hDEADBEEF, 0));
    st.push_back(mk(OP_LW, 32'h104, 32'h12345678, 1, 0, 0, 3, 2, 0, 32'h12345678, 0));
    test_steps("lw", st);
  endtask

  task automatic test_ll_sc();
    step_t st[$];
    st.push_back(mk(OP_LL, 32'h200, 32'hA5A50001, 0, 0, 0, 2, 1, 0, 32'hA5A50001, 0));
    st.push_back(mk(OP_SC, 32'h200, 32'h5,        1, 0, 0, 3, 0, 2, 32'hA5A50001, 1));
    st.push_back(mk(OP_SC, 32'h200, 32'h6,        0, 0, 0, 1, 0, 0, 32'hA5A50001, 0));
    st.push_back(mk(OP_LL, 32'h200, 32'hA5A50002, 0, 0, 0, 2, 1, 0, 32'hA5A50002, 0));
    st.push_back(mk(OP_SC, 32'h203, 32'h7,        0, 0, 0, 2, 0, 1, 32'hA5A50002, 1));
    test_steps("ll_sc", st);
  endtask

  task automatic test_snoop();
    step_t st[$];
    st.push_back(mk(OP_LL, 32'h200, 32'h33, 0, 0, 0, 2, 1, 0, 32'h33, 1));
    test_steps("snoop_a", st);
    snoop_pulse(32'h300);
    st = {};
    st.push_back(mk(OP_SC, 32'h200, 32'h1, 0, 0, 0, 2, 0, 1, 32'h33, 1));
    st.push_back(mk(OP_LL, 32'h200, 32'h34, 0, 0, 0, 2, 1, 0, 32'h34, 1));
    test_steps("snoop_b", st);
    snoop_pulse(32'h202);
    st = {};
    st.push_back(mk(OP_SC, 32'h200, 32'h2,  0, 0, 0, 1, 0, 0, 32'h34, 0));
    st.push_back(mk(OP_LL, 32'h200, 32'h35, 1, 1, 0, 3, 2, 0, 32'h35, 0));
    st.push_back(mk(OP_SC, 32'h200, 32'h3,  0, 0, 0, 1, 0, 0, 32'h35, 0));
    st.push_back(mk(OP_LL, 32'h200, 32'h36, 0, 0, 0, 2, 1, 0, 32'h36, 0));
    st.push_back(mk(OP_SC, 32'h200, 32'h4,  1, 1, 0, 3, 0, 2, 32'h36, 1));
    st.push_back(mk(OP_SC, 32'h200, 32'h8,  0, 0, 0, 1, 0, 0, 32'h36, 0));
    test_steps("snoop_c", st);
  endtask

  task automatic test_sw_link();
    step_t st[$];
    st.push_back(mk(OP_LL, 32'h200, 32'h44, 0, 0, 0, 2, 1, 0, 32'h44, 0));
    st.push_back(mk(OP_SW, 32'h204, 32'h55, 0, 0, 0, 2, 0, 1, 32'h44, 0));
    st.push_back(mk(OP_SC, 32'h200, 32'h9,  0, 0, 0, 2, 0, 1, 32'h44, 1));
    st.push_back(mk(OP_LL, 32'h200, 32'h66, 0, 0, 0, 2, 1, 0, 32'h66, 1));
    st.push_back(mk(OP_SW, 32'h204, 32'h77, 0, 0, 0, 2, 0, 1, 32'h66, 1));
    st.push_back(mk(OP_SW, 32'h200, 32'h88, 1, 0, 0, 3, 0, 2, 32'h66, 1));
    st.push_back(mk(OP_SC, 32'h200, 32'hA,  0, 0, 0, 1, 0, 0, 32'h66, 0));
    test_steps("sw_link", st);
  endtask

  task automatic test_flush();
    step_t st[$];
    @(negedge CLK);
    valid_EX_MEM = 1; memREN_EX_MEM = 1; addr_EX_MEM = 32'h400; flush_MEM = 1;
    #1;
    n_assert++; if (mem_busy !== 0) begin n_fail++; $display("FAIL flush_idle_busy: got %b want 0", mem_busy); end
    @(negedge CLK); #1;
    n_assert++; if (dmemREN !== 0) begin n_fail++; $display("FAIL flush_idle_ren: got %b want 0", dmemREN); end
    drive_idle();
    st.push_back(mk(OP_LW, 32'h400, 32'h77, 3, 0, 1, 5, 4, 0, 32'h77, 0));
    test_steps("flush_req", st);
  endtask

  task automatic test_reset_mid_req();
    step_t st[$];
    st.push_back(mk(OP_LL, 32'h500, 32'h88, 0, 0, 0, 2, 1, 0, 32'h88, 0));
    test_steps("rst_pre", st);
    @(negedge CLK);
    valid_EX_MEM = 1; memREN_EX_MEM = 1; addr_EX_MEM = 32'h600;
    @(negedge CLK); #1;
    n_assert++; if (dmemREN !== 1) begin n_fail++; $display("FAIL rst_req_entry: got %b want 1", dmemREN); end
    nRST = 0;
    #1;
    n_assert++; if (dmemREN !== 0)  begin n_fail++; $display("FAIL rst_async_ren: got %b want 0", dmemREN); end
    n_assert++; if (dmemaddr !== 0) begin n_fail++; $display("FAIL rst_async_addr: got %h want 0", dmemaddr); end
    n_assert++; if (dmemload_MEM !== 0) begin n_fail++; $display("FAIL rst_async_load: got %h want 0", dmemload_MEM); end
    drive_idle();
    #1;
    n_assert++; if (mem_busy !== 0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", mem_busy); end
    @(negedge CLK);
    nRST = 1;
    st = {};
    st.push_back(mk(OP_SC, 32'h500, 32'hB,  0, 0, 0, 1, 0, 0, 32'h0,  0));
    st.push_back(mk(OP_LW, 32'h600, 32'h99, 0, 0, 0, 2, 1, 0, 32'h99, 0));
    test_steps("rst_post", st);
  endtask

  task automatic test_back_to_back();
    step_t st[$];
    @(negedge CLK);
    valid_EX_MEM = 1;
    #1;
    n_assert++; if (mem_busy !== 0) begin n_fail++; $display("FAIL nonmem_busy: got %b want 0", mem_busy); end
    drive_idle();
    st.push_back(mk(OP_LW, 32'h700, 32'hCAFE0001, 0, 0, 0, 2, 1, 0, 32'hCAFE0001, 0));
    st.push_back(mk(OP_LW, 32'h704, 32'hCAFE0002, 0, 0, 0, 2, 1, 0, 32'hCAFE0002, 0));
    st.push_back(mk(OP_SW, 32'h708, 32'hCAFE0003, 2, 0, 0, 4, 0, 3, 32'hCAFE0002, 0));
    test_steps("b2b", st);
  endtask

  initial begin
    test_reset();
    test_lw();
    test_ll_sc();
    test_snoop();
    test_sw_link();
    test_flush();
    test_reset_mid_req();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
